tribus_arbiter: RTL and testbench
=================================

Name: tribus_arbiter

Overview:
- Sequences ownership of a shared tristate bus between N requesters.
- All request, enable and bus-sense signals use the same dual-rail 4-valued encoding as the tristate buffer netlists in this design.
- Asserts exactly one driver enable at a time, inserts a Z turnaround gap between owners, and rotates owners round-robin with a hold limit.
- Monitors the resolved bus for contention (X) and for a foreign driver during idle.

Parameters:
- N, 4: number of requesters/drivers; legal range 2..16.
- TURN_CYC, 1: number of all-disabled cycles between owners; minimum 1.
- MAX_HOLD, 8: owner cycles after which the owner yields if another valid request is pending; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_b1  in  N  dual-rail request, high rail, one bit per requester.
- req_b0  in  N  dual-rail request, low rail, one bit per requester.
- bus_b1  in  1  resolved bus value sensed back, high rail.
- bus_b0  in  1  resolved bus value sensed back, low rail.
- err_clr  in  1  clears the sticky flags.
- en_b1  out  N  dual-rail driver enable, high rail; always 0.
- en_b0  out  N  dual-rail driver enable, low rail; one-hot or zero.
- gnt_valid  out  1  a driver currently owns the bus.
- gnt_id  out  clog2(N)  index of the current or last owner.
- req_err  out  1  sticky: a request was seen as Z or X.
- bus_err  out  1  sticky: contention or foreign driver detected on the bus.

Behaviour:
- Encoding of {b1,b0}: 00 = logic 0, 01 = logic 1, 10 = Z, 11 = X. The enables only ever take the values 00 or 01.
- Request decode: 01 = requesting; 00 = idle; 10 or 11 = treated as idle and sets req_err in the same cycle.
- Reset values, applied asynchronously: state IDLE, en_b1 = en_b0 = 0, gnt_valid 0, gnt_id 0, rr pointer = N-1 (so index 0 has first priority), hold_cnt 0, turn_cnt 0, req_err 0, bus_err 0.
- Reset while in OWN drops the enable immediately, without waiting for a clock edge.
- Arbitration is round-robin: search starts at pointer+1 and wraps modulo N. On each grant the pointer is set to the winner.
- IDLE:
  - Any valid request -> OWN at the next edge. Latency is one cycle from request to enable.
  - en_b0[winner] = 1; gnt_valid = 1; gnt_id = winner; hold_cnt = 0.
- OWN:
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Exit to TURN when either (a) the owner's request decodes to anything other than 01, or (b) hold_cnt = MAX_HOLD-1 and another valid request is pending.
  - If no other request is pending, the owner keeps the bus indefinitely.
  - On exit the enable drops at the same edge, gnt_valid goes to 0, and gnt_id holds its value.
- TURN:
  - All enables are 0 for exactly TURN_CYC cycles, counted by turn_cnt.
  - After the last cycle: any valid request -> OWN with a fresh round-robin pick; otherwise -> IDLE.
  - The previous owner is eligible again only if no other requester is valid.
- Simultaneous requests in IDLE: lowest index at or after pointer+1 (modulo N) wins.
- Bus monitor, in OWN from the 2nd ownership cycle onward: bus decodes to 11 -> set bus_err.
- Bus monitor, in IDLE or in the final TURN cycle: bus decodes to 00 or 01 -> set bus_err (foreign driver).
- bus_err is never set during the first OWN cycle or the non-final TURN cycles; these are settling windows.
- Sticky flags: err_clr clears them at the next edge. If a set condition occurs in the same cycle as err_clr, the set wins.
- Invariant: popcount(en_b0) <= 1 in every cycle, and en_b0 is 0 whenever the state is not OWN.

Decomposition:
- Shared package tribus_pkg:
  - 2-bit encoding constants L0, L1, LZ, LX.
  - State enum: IDLE, OWN, TURN.
  - Function dr_decode returning {is0, is1, isZ, isX}.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: N-bit valid vector and pointer.
  - Outputs: any, winner index.
  - Reused by the future multi-bus controller.

Test Plan (N=4, TURN_CYC=1, MAX_HOLD=4):
- Reset, then req[2]=01 -> en_b0 = 0100 one cycle later; gnt_id = 2, gnt_valid = 1.
- req[0] and req[3] both 01 from IDLE with pointer 2 -> req[3] wins; after owner 3 releases: 1 TURN cycle with en = 0000, then owner 0.
- req[1] held at 01 with req[2] pending -> owner 1 for 4 cycles, 1 TURN cycle, then owner 2. With no rival pending, owner 1 keeps the bus beyond 4 cycles.
- Owner's request goes to 11 mid-ownership -> enable drops next edge, req_err = 1; err_clr pulse clears it. err_clr in the same cycle as a new X on a request -> req_err stays 1.
- Bus driven 11 during the 3rd OWN cycle -> bus_err = 1. Bus 01 while IDLE -> bus_err = 1. Bus 11 in the 1st OWN cycle -> no flag.
- rst asserted mid-OWN, between clock edges -> en_b0 = 0000 immediately; after release, first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/tribus_pkg.sv
// Shared dual-rail 4-valued encoding, arbiter state type and decoder.
// Encoding of {b1,b0}: 00 = 0, 01 = 1, 10 = Z, 11 = X.
package tribus_pkg;

    localparam logic [1:0] L0 = 2'b00;
    localparam logic [1:0] L1 = 2'b01;
    localparam logic [1:0] LZ = 2'b10;
    localparam logic [1:0] LX = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    typedef struct packed {
        logic is0;
        logic is1;
        logic isz;
        logic isx;
    } dr_t;

    function automatic dr_t dr_decode(input logic b1, input logic b0);
        dr_t d;
        d.is0 = ({b1, b0} == L0);
        d.is1 = ({b1, b0} == L1);
        d.isz = ({b1, b0} == LZ);
        d.isx = ({b1, b0} == LX);
        return d;
    endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after ptr, wrapping modulo N.
// Zero latency; no flow control.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] idx;

    // Scanning from farthest to nearest leaves the nearest valid index after ptr.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (valid[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner sequencer for a shared tristate bus with Z turnaround and hold limit.
// Enable follows a request by one cycle; an owner yields after MAX_HOLD cycles only to a rival.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int N        = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_b1,
    input  logic [N-1:0]         req_b0,
    input  logic                 bus_b1,
    input  logic                 bus_b0,
    input  logic                 err_clr,
    output logic [N-1:0]         en_b1,
    output logic [N-1:0]         en_b0,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 req_err,
    output logic                 bus_err
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    state_t        state, state_nxt;
    logic [N-1:0]  en_nxt;
    logic          gv_nxt;
    logic [IW-1:0] gid_nxt, ptr, ptr_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [TW-1:0] turn_cnt, turn_nxt;

    logic [N-1:0]  req_vld, req_bad, others;
    logic          bus_x, bus_drv, bus_set, turn_last;
    logic          pick_any;
    logic [IW-1:0] pick_id;
    dr_t           rd, bd;

    always_comb begin
        req_vld = '0;
        req_bad = '0;
        rd      = '0;
        for (int i = 0; i < N; i++) begin
            rd         = dr_decode(req_b1[i], req_b0[i]);
            req_vld[i] = rd.is1 & ~rd.is0;
            req_bad[i] = rd.isz | rd.isx;
        end
        bd      = dr_decode(bus_b1, bus_b0);
        bus_x   = bd.isx & ~bd.isz;
        bus_drv = bd.is0 | bd.is1;
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .valid  (req_vld),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_id)
    );

    assign en_b1     = '0;
    assign turn_last = (state == TURN) && (turn_cnt == TW'(TURN_CYC - 1));

    // First OWN cycle and early TURN cycles are settling windows for the bus.
    assign bus_set = ((state == OWN) && (hold_cnt != '0) && bus_x) ||
                     (((state == IDLE) || turn_last) && bus_drv);

    always_comb begin
        state_nxt = state;
        en_nxt    = en_b0;
        gv_nxt    = gnt_valid;
        gid_nxt   = gnt_id;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        turn_nxt  = turn_cnt;
        others    = req_vld;
        others[gnt_id] = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (state == TURN && !turn_last) begin
                    turn_nxt = turn_cnt + TW'(1);
                end else if (pick_any) begin
                    state_nxt       = OWN;
                    en_nxt          = '0;
                    en_nxt[pick_id] = 1'b1;
                    gv_nxt          = 1'b1;
                    gid_nxt         = pick_id;
                    ptr_nxt         = pick_id;
                    hold_nxt        = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN: begin
                if (!req_vld[gnt_id] ||
                    ((hold_cnt == HW'(MAX_HOLD - 1)) && (|others))) begin
                    state_nxt = TURN;
                    en_nxt    = '0;
                    gv_nxt    = 1'b0;
                    turn_nxt  = '0;
                end else if (hold_cnt != HW'(MAX_HOLD)) begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                en_nxt    = '0;
                gv_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en_b0     <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= IW'(N - 1);
            hold_cnt  <= '0;
            turn_cnt  <= '0;
            req_err   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            en_b0     <= en_nxt;
            gnt_valid <= gv_nxt;
            gnt_id    <= gid_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            turn_cnt  <= turn_nxt;
            req_err   <= (|req_bad) | (req_err & ~err_clr);
            bus_err   <= bus_set | (bus_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter: directed scenarios plus random traffic vs. a behavioural model.
module tb_tribus_arbiter;

    localparam int N        = 4;
    localparam int TURN_CYC = 1;
    localparam int MAX_HOLD = 4;
    localparam int IW       = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_b1 = '0, req_b0 = '0;
    logic          bus_b1 = 1'b1, bus_b0 = 1'b0;
    logic          err_clr = 1'b0;
    logic [N-1:0]  en_b1, en_b0;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          req_err, bus_err;

    tribus_arbiter #(.N(N), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_b1    (req_b1),
        .req_b0    (req_b0),
        .bus_b1    (bus_b1),
        .bus_b0    (bus_b0),
        .err_clr   (err_clr),
        .en_b1     (en_b1),
        .en_b0     (en_b0),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .req_err   (req_err),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  en_b1;
        logic [N-1:0]  en_b0;
        logic          gv;
        logic [IW-1:0] gid;
        logic          re;
        logic          be;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: owner index (-1 = none), cycles owned, TURN cycles left.
    int m_owner = -1, m_held = 0, m_turn_left = 0, m_ptr = N - 1, m_gid = 0;
    bit m_req_err = 1'b0, m_bus_err = 1'b0;

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_turn_left = 0; m_ptr = N - 1; m_gid = 0;
        m_req_err = 1'b0; m_bus_err = 1'b0;
    endtask

    task automatic model_step();
        bit [N-1:0] vld;
        bit         bad, others, quiet_win, bus_set;
        logic [1:0] b;
        int         w, j;
        vld = '0;
        bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            vld[i] = ({req_b1[i], req_b0[i]} == 2'b01);
            if (req_b1[i]) bad = 1'b1;
        end
        b = {bus_b1, bus_b0};
        quiet_win = (m_owner < 0) && (m_turn_left <= 1);
        bus_set = ((m_owner >= 0) && (m_held > 0) && (b == 2'b11)) || (quiet_win && !b[1]);
        m_req_err = bad || (m_req_err && !err_clr);
        m_bus_err = bus_set || (m_bus_err && !err_clr);
        if (m_owner >= 0) begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && vld[i]) others = 1'b1;
            if (!vld[m_owner] || (m_held == MAX_HOLD - 1 && others)) begin
                m_owner = -1;
                m_turn_left = TURN_CYC;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else if (m_turn_left > 1) begin
            m_turn_left--;
        end else begin
            m_turn_left = 0;
            w = -1;
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && vld[j]) w = j;
            end
            if (w >= 0) begin
                m_owner = w; m_gid = w; m_ptr = w; m_held = 0;
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.en_b1 = '0;
        o.en_b0 = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        o.gv    = (m_owner >= 0);
        o.gid   = IW'(m_gid);
        o.re    = m_req_err;
        o.be    = m_bus_err;
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step();
            exp_q.push_back(model_obs());
        end
    end

    always @(negedge clk) begin
        obs_t e, a;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {en_b1, en_b0, gnt_valid, gnt_id, req_err, bus_err};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_outputs t=%0t got {en_b1,en_b0,gv,gid,re,be}=%h expected %h",
                          $time, a, e);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, want);
    endtask

    task automatic set_req(input int i, input logic [1:0] code);
        req_b1[i] = code[1];
        req_b0[i] = code[0];
    endtask

    // Advance to just after the next falling edge; the bus reflects the model's owner by default.
    task automatic step_cycle();
        @(negedge clk);
        #1;
        if (m_owner >= 0) {bus_b1, bus_b0} = {1'b0, 1'($urandom % 2)};
        else {bus_b1, bus_b0} = 2'b10;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    bit [N-1:0] hold_vld = '0;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_en_b0", 32'(en_b0), 32'h0);
        check("rst_en_b1", 32'(en_b1), 32'h0);
        check("rst_gnt", 32'({gnt_valid, gnt_id}), 32'h0);
        check("rst_flags", 32'({req_err, bus_err}), 32'h0);
        rst = 1'b0;

        // Single request: one-cycle latency.
        set_req(2, 2'b01);
        step_cycle();
        check("t1_en_b0", 32'(en_b0), 32'h4);
        check("t1_gnt", 32'({gnt_valid, gnt_id}), 32'h6);
        set_req(2, 2'b00);
        steps(2);

        // Simultaneous 0 and 3 with pointer 2: 3 wins, then one Z cycle, then 0.
        set_req(0, 2'b01); set_req(3, 2'b01);
        step_cycle();
        check("t2_first_id", 32'(gnt_id), 32'h3);
        set_req(3, 2'b00);
        step_cycle();
        check("t2_turn_en", 32'(en_b0), 32'h0);
        check("t2_turn_gnt", 32'({gnt_valid, gnt_id}), 32'h3);
        step_cycle();
        check("t2_next_en", 32'(en_b0), 32'h1);
        set_req(0, 2'b00);
        steps(2);

        // Hold limit with a rival pending, then unlimited hold without one.
        set_req(1, 2'b01); set_req(2, 2'b01);
        step_cycle();
        check("t3_own_c1", 32'(en_b0), 32'h2);
        steps(3);
        check("t3_own_c4", 32'(en_b0), 32'h2);
        step_cycle();
        check("t3_turn", 32'(en_b0), 32'h0);
        step_cycle();
        check("t3_rival", 32'({en_b0, gnt_id}), 32'({4'h4, 2'd2}));
        set_req(2, 2'b00);
        steps(2);
        check("t3_back1", 32'(en_b0), 32'h2);
        steps(8);
        check("t3_long_hold", 32'({gnt_valid, en_b0}), 32'h12);

        // X on the owner's request, clear, and set-beats-clear.
        set_req(1, 2'b11);
        step_cycle();
        check("t4_drop", 32'({en_b0, req_err}), 32'h1);
        set_req(1, 2'b00);
        step_cycle();
        err_clr = 1'b1;
        step_cycle();
        err_clr = 1'b0;
        check("t4_clr", 32'(req_err), 32'h0);
        err_clr = 1'b1; set_req(3, 2'b11);
        step_cycle();
        check("t4_set_wins", 32'(req_err), 32'h1);
        set_req(3, 2'b00);
        step_cycle();
        err_clr = 1'b0;
        check("t4_clr2", 32'(req_err), 32'h0);

        // Bus monitor windows.
        set_req(0, 2'b01);
        step_cycle();
        {bus_b1, bus_b0} = 2'b11;
        step_cycle();
        check("t5_settle_x", 32'(bus_err), 32'h0);
        step_cycle();
        {bus_b1, bus_b0} = 2'b11;
        step_cycle();
        check("t5_own_x", 32'(bus_err), 32'h1);
        err_clr = 1'b1;
        step_cycle();
        err_clr = 1'b0;
        check("t5_clr", 32'(bus_err), 32'h0);
        set_req(0, 2'b00);
        steps(2);
        {bus_b1, bus_b0} = 2'b01;
        step_cycle();
        check("t5_foreign", 32'(bus_err), 32'h1);
        err_clr = 1'b1;
        step_cycle();
        err_clr = 1'b0;
        check("t5_clr2", 32'(bus_err), 32'h0);

        // Reset between edges while owning.
        set_req(2, 2'b01);
        steps(2);
        check("t6_owning", 32'(en_b0), 32'h4);
        #1 rst = 1'b1;
        #1 check("t6_async_drop", 32'({en_b0, gnt_valid}), 32'h0);
        step_cycle();
        rst = 1'b0;
        set_req(1, 2'b01); set_req(3, 2'b01);
        step_cycle();
        check("t6_first_after_rst", 32'(gnt_id), 32'h1);
        set_req(1, 2'b00); set_req(2, 2'b00); set_req(3, 2'b00);
        steps(3);

        // Random traffic with persistent requests, occasional Z/X and bus faults.
        for (int c = 0; c < 2000; c++) begin
            int r;
            step_cycle();
            if ($urandom % 32 == 0) {bus_b1, bus_b0} = 2'($urandom);
            for (int i = 0; i < N; i++) begin
                r = int'($urandom % 64);
                if (r < 6) hold_vld[i] = ~hold_vld[i];
                if (r == 63) set_req(i, {1'b1, 1'($urandom % 2)});
                else set_req(i, {1'b0, hold_vld[i]});
            end
            err_clr = ($urandom % 16 == 0);
        end
        err_clr = 1'b0;
        steps(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
